// File: rtl/plic_target_ctrl.sv
// -----------------------------------------------------------------------------
// plic_target_ctrl
//
// Hart-side context controller at the target end of a PLIC. It turns the PLIC
// level notification into a claim pulse, reads the claimed ID back over the
// Avalon-MM master port, presents the ID to the core, and sends the complete
// pulse once the core signals end-of-interrupt. Core configuration writes
// (IE / THRESHOLD / PRIORITY) are forwarded onto the same Avalon port while
// the controller is idle.
//
// Ports
//   clk_i, resetn_i       clock (rising edge), asynchronous active-low reset
//   irq_notify_i          PLIC notification (level)
//   irq_claim_o           PLIC claim, one-cycle pulse
//   irq_complete_o        PLIC complete, one-cycle pulse
//   avm_*                 Avalon-MM master (chipselect/read/write/address/data)
//   cfg_valid_i/ready_o   core config write handshake, cfg_addr_i/cfg_data_i
//   core_irq_o            interrupt pending to the core, core_irq_id_o its ID
//   core_ack_i            core takes the interrupt
//   core_eoi_i            core end-of-interrupt (only honoured in SERVICE)
//   busy_o                controller not idle
//   spurious_cnt_o        saturating count of claims that returned ID 0
//
// Config handshake: a write transfers in a cycle where cfg_valid_i and
// cfg_ready_o are both 1. cfg_ready_o is only ever raised in an IDLE cycle
// with no pending notification, and it is a decode of registered state plus
// the requester's own inputs, so the requester must hold valid, address and
// data stable until it sees ready.
// -----------------------------------------------------------------------------
module plic_target_ctrl #(
    parameter int ID_W         = 3,
    parameter int CLAIM_WAIT   = 2,  // min 1
    parameter int READ_LATENCY = 1,  // min 1
    parameter int GUARD        = 2,  // min 1
    parameter int CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             irq_notify_i,
    output logic             irq_claim_o,
    output logic             irq_complete_o,
    output logic             avm_chipselect_o,
    output logic             avm_read_o,
    output logic             avm_write_o,
    output logic [1:0]       avm_address_o,
    output logic [31:0]      avm_writedata_o,
    input  logic [31:0]      avm_readdata_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [1:0]       cfg_addr_i,
    input  logic [31:0]      cfg_data_i,
    output logic             core_irq_o,
    output logic [ID_W-1:0]  core_irq_id_o,
    input  logic             core_ack_i,
    input  logic             core_eoi_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] spurious_cnt_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CFG_WR   = 4'd1;
    localparam logic [3:0] S_CLAIM    = 4'd2;
    localparam logic [3:0] S_WAIT_ID  = 4'd3;
    localparam logic [3:0] S_RD_REQ   = 4'd4;
    localparam logic [3:0] S_RD_WAIT  = 4'd5;
    localparam logic [3:0] S_PRESENT  = 4'd6;
    localparam logic [3:0] S_SERVICE  = 4'd7;
    localparam logic [3:0] S_COMPLETE = 4'd8;
    localparam logic [3:0] S_GUARD    = 4'd9;

    localparam logic [1:0] ADDR_ID = 2'd3;

    // One shared timer serves the three timed states.
    localparam int M1   = (CLAIM_WAIT > READ_LATENCY) ? CLAIM_WAIT : READ_LATENCY;
    localparam int MAXC = (M1 > GUARD) ? M1 : GUARD;
    localparam int TW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    localparam logic [TW-1:0] CW_LAST = TW'(CLAIM_WAIT - 1);
    localparam logic [TW-1:0] RL_LAST = TW'(READ_LATENCY - 1);
    localparam logic [TW-1:0] GD_LAST = TW'(GUARD - 1);

    logic [3:0]      state;
    logic [3:0]      state_nx;
    logic [TW-1:0]   tmr;
    logic            run_q;
    logic            cfg_accept;
    logic            id_take;
    logic [ID_W-1:0] id_smp;
    logic            unused_rd;

    assign id_smp    = avm_readdata_i[ID_W-1:0];
    assign unused_rd = ^avm_readdata_i[31:ID_W];

    // run_q is 0 while reset is asserted, which keeps cfg_ready_o low during
    // reset and for the first cycle after release.
    assign cfg_ready_o = cfg_accept;

    always_comb begin
        state_nx   = state;
        cfg_accept = 1'b0;
        id_take    = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_q) begin
                    // A pending notification beats a config request.
                    if (irq_notify_i) begin
                        state_nx = S_CLAIM;
                    end else if (cfg_valid_i) begin
                        state_nx   = S_CFG_WR;
                        cfg_accept = 1'b1;
                    end
                end
            end
            S_CFG_WR:   state_nx = S_IDLE;
            S_CLAIM:    state_nx = S_WAIT_ID;
            S_WAIT_ID:  if (tmr == CW_LAST) state_nx = S_RD_REQ;
            S_RD_REQ:   state_nx = S_RD_WAIT;
            S_RD_WAIT: begin
                if (tmr == RL_LAST) begin
                    id_take  = 1'b1;
                    // ID 0 means nothing was pending: no present, no complete.
                    state_nx = (id_smp == '0) ? S_GUARD : S_PRESENT;
                end
            end
            // eoi arriving with ack is deliberately not carried into SERVICE.
            S_PRESENT:  if (core_ack_i) state_nx = S_SERVICE;
            S_SERVICE:  if (core_eoi_i) state_nx = S_COMPLETE;
            S_COMPLETE: state_nx = S_GUARD;
            S_GUARD:    if (tmr == GD_LAST) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state <= S_IDLE;
            tmr   <= '0;
            run_q <= 1'b0;
        end else begin
            state <= state_nx;
            run_q <= 1'b1;
            if (state_nx != state) begin
                tmr <= '0;
            end else if (state == S_WAIT_ID || state == S_RD_WAIT || state == S_GUARD) begin
                tmr <= tmr + 1'b1;
            end
        end
    end

    // Outputs are registered from the next-state decode so that each one is
    // asserted in exactly the cycle its state is occupied.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            irq_claim_o      <= 1'b0;
            irq_complete_o   <= 1'b0;
            avm_chipselect_o <= 1'b0;
            avm_read_o       <= 1'b0;
            avm_write_o      <= 1'b0;
            avm_address_o    <= '0;
            avm_writedata_o  <= '0;
            core_irq_o       <= 1'b0;
            core_irq_id_o    <= '0;
            busy_o           <= 1'b0;
            spurious_cnt_o   <= '0;
        end else begin
            irq_claim_o    <= (state_nx == S_CLAIM);
            irq_complete_o <= (state_nx == S_COMPLETE);
            core_irq_o     <= (state_nx == S_PRESENT);
            busy_o         <= (state_nx != S_IDLE);
            avm_read_o     <= (state_nx == S_RD_REQ);
            // The ID register is read-only: a config write aimed at it still
            // costs the CFG_WR cycle but never reaches the bus.
            avm_write_o      <= cfg_accept && (cfg_addr_i != ADDR_ID);
            avm_chipselect_o <= (state_nx == S_RD_REQ) ||
                                (cfg_accept && (cfg_addr_i != ADDR_ID));

            if (cfg_accept) begin
                avm_address_o   <= cfg_addr_i;
                avm_writedata_o <= cfg_data_i;
            end else if (state_nx == S_RD_REQ) begin
                avm_address_o <= ADDR_ID;
            end

            if (id_take) begin
                if (id_smp != '0) begin
                    core_irq_id_o <= id_smp;
                end else if (spurious_cnt_o != '1) begin
                    spurious_cnt_o <= spurious_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_plic_target_ctrl.sv
module tb_plic_target_ctrl;

    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic             irq_notify = 1'b0;
    logic             irq_claim_o, irq_complete_o;
    logic             avm_chipselect_o, avm_read_o, avm_write_o;
    logic [1:0]       avm_address_o;
    logic [31:0]      avm_writedata_o;
    logic [31:0]      avm_readdata = 32'd0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready_o;
    logic [1:0]       cfg_addr = 2'd0;
    logic [31:0]      cfg_data = 32'd0;
    logic             core_irq_o;
    logic [ID_W-1:0]  core_irq_id_o;
    logic             core_ack = 1'b0;
    logic             core_eoi = 1'b0;
    logic             busy_o;
    logic [CNT_W-1:0] spurious_cnt_o;

    plic_target_ctrl dut (
        .clk_i            (clk),
        .resetn_i         (resetn),
        .irq_notify_i     (irq_notify),
        .irq_claim_o      (irq_claim_o),
        .irq_complete_o   (irq_complete_o),
        .avm_chipselect_o (avm_chipselect_o),
        .avm_read_o       (avm_read_o),
        .avm_write_o      (avm_write_o),
        .avm_address_o    (avm_address_o),
        .avm_writedata_o  (avm_writedata_o),
        .avm_readdata_i   (avm_readdata),
        .cfg_valid_i      (cfg_valid),
        .cfg_ready_o      (cfg_ready_o),
        .cfg_addr_i       (cfg_addr),
        .cfg_data_i       (cfg_data),
        .core_irq_o       (core_irq_o),
        .core_irq_id_o    (core_irq_id_o),
        .core_ack_i       (core_ack),
        .core_eoi_i       (core_eoi),
        .busy_o           (busy_o),
        .spurious_cnt_o   (spurious_cnt_o)
    );

    // ---------------- counters / check ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- Avalon read responder (latency 1) ----------------
    // Outside the valid cycle the bus carries the complement of the answer,
    // so a mistimed sample returns a wrong ID.
    logic [31:0] rsp_data = 32'd0;
    logic        rd_flag  = 1'b0;
    always @(negedge clk) rd_flag = avm_read_o;
    always @(posedge clk) begin
        #1;
        avm_readdata = rd_flag ? rsp_data : ~rsp_data;
    end

    // ---------------- scoreboard: Avalon accesses ----------------
    // entry = {chipselect, read, write, address, write-data (0 for reads)}
    logic [36:0] exp_q[$];
    logic [36:0] sb_got, sb_exp;
    localparam logic [36:0] EXP_RD = {1'b1, 1'b1, 1'b0, 2'd3, 32'd0};

    int   rd_c = -100;
    int   complete_c = -100;
    int   complete_cnt = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (avm_read_o) rd_c = cyc;
            if (irq_complete_o) begin
                complete_cnt++;
                complete_c = cyc;
            end
            if (cfg_ready_o && busy_o) begin
                total++;
                bad++;
                $display("FAIL ready_while_busy: cfg_ready_o=1 busy_o=1 required cfg_ready_o=0 (cycle %0d)", cyc);
            end
            if (avm_chipselect_o || avm_read_o || avm_write_o) begin
                sb_got = {avm_chipselect_o, avm_read_o, avm_write_o, avm_address_o,
                          avm_write_o ? avm_writedata_o : 32'd0};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL avm_unexpected: got=0x%0h expected no access (cycle %0d)", sb_got, cyc);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (sb_got !== sb_exp) begin
                        bad++;
                        $display("FAIL avm_access: got=0x%0h expected=0x%0h (cycle %0d)", sb_got, sb_exp, cyc);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int spur_exp = 0;

    task automatic wait_idle(output int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < 60);
        if (busy_o) check("idle_timeout", 64'(busy_o), 64'd0);
        c = cyc;
    endtask

    task automatic wait_claim(output int cc, output bit ok);
        int n = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!irq_claim_o && n < 20);
        cc = cyc;
        if (irq_claim_o) ok = 1'b1;
        else check("claim_timeout", 64'(irq_claim_o), 64'd1);
    endtask

    // Entered at the negedge of the first PRESENT cycle.
    task automatic service(input logic [2:0] exp_id, input int d_ack, input int d_eoi);
        int ic;
        int cb;
        repeat (d_ack + 1) @(posedge clk);
        #1 core_ack = 1'b1;
        @(negedge clk);
        check("irq_held_until_ack", 64'(core_irq_o), 64'd1);
        @(posedge clk);
        #1 core_ack = 1'b0;
        @(negedge clk);
        check("irq_drop_after_ack", 64'(core_irq_o), 64'd0);
        check("id_stable_service", 64'(core_irq_id_o), 64'(exp_id));
        check("busy_in_service", 64'(busy_o), 64'd1);
        cb = complete_cnt;
        repeat (d_eoi + 1) @(posedge clk);
        #1 core_eoi = 1'b1;
        @(posedge clk);
        #1 core_eoi = 1'b0;
        wait_idle(ic);
        check("complete_once", 64'(complete_cnt - cb), 64'd1);
        check("guard_len", 64'(ic - complete_c), 64'd3);
    endtask

    task automatic run_irq(input logic [31:0] rdata, input logic exp_irq, input logic [2:0] exp_id,
                           input int d_ack, input int d_eoi);
        int cc;
        int ic;
        int cb;
        bit ok;
        wait_idle(ic);
        cb = complete_cnt;
        rsp_data = rdata;
        exp_q.push_back(EXP_RD);
        @(posedge clk);
        #1 irq_notify = 1'b1;
        wait_claim(cc, ok);
        if (!ok) begin
            irq_notify = 1'b0;
            return;
        end
        // Dropping notify after the claim must not disturb the sequence.
        @(posedge clk);
        #1 irq_notify = 1'b0;
        while (cyc < cc + 4) @(negedge clk);
        check("claim_to_read", 64'(rd_c - cc), 64'd3);
        check("irq_not_early", 64'(core_irq_o), 64'd0);
        @(negedge clk);
        if (exp_irq) begin
            check("irq_at_n5", 64'(core_irq_o), 64'd1);
            check("irq_id", 64'(core_irq_id_o), 64'(exp_id));
            service(exp_id, d_ack, d_eoi);
        end else begin
            spur_exp = (spur_exp == 255) ? 255 : spur_exp + 1;
            check("spur_no_irq", 64'(core_irq_o), 64'd0);
            check("spur_cnt", 64'(spurious_cnt_o), 64'(spur_exp));
            wait_idle(ic);
            check("spur_claim_to_idle", 64'(ic - cc), 64'd7);
            check("spur_no_complete", 64'(complete_cnt - cb), 64'd0);
        end
    endtask

    task automatic run_cfg(input logic [1:0] a, input logic [31:0] d, input logic exp_ready,
                           input logic exp_wr);
        int ic;
        wait_idle(ic);
        if (exp_wr) exp_q.push_back({1'b1, 1'b0, 1'b1, a, d});
        @(posedge clk);
        #1;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        @(negedge clk);
        check("cfg_ready", 64'(cfg_ready_o), 64'(exp_ready));
        @(posedge clk);
        // Scramble the request lines to show the write uses the accepted copy.
        #1;
        cfg_valid = 1'b0;
        cfg_addr  = 2'($urandom_range(0, 3));
        cfg_data  = $urandom;
        @(negedge clk);
        check("cfg_wr_busy", 64'(busy_o), 64'd1);
        check("cfg_wr_strobe", 64'(avm_write_o), 64'(exp_wr));
        check("cfg_ready_one_cycle", 64'(cfg_ready_o), 64'd0);
        @(negedge clk);
        check("cfg_back_idle", 64'(busy_o), 64'd0);
        check("cfg_wr_single", 64'(avm_write_o), 64'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_irq;
        logic [1:0]  addr;
        logic [31:0] data;      // config data, or Avalon read data for irq
        logic        exp_ready;
        logic        exp_wr;
        logic        exp_irq;
        logic [2:0]  exp_id;
    } vec_t;

    vec_t vecs[9];

    // ---------------- main sequence ----------------
    initial begin
        int cc;
        int ic;
        int cb;
        bit ok;

        vecs[0] = '{1'b0, 2'd2, 32'h0000_0249, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[1] = '{1'b0, 2'd3, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 2'd0, 32'h0000_0005, 1'b0, 1'b0, 1'b1, 3'd5};
        vecs[3] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[4] = '{1'b1, 2'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{1'b1, 2'd0, 32'hABCD_0008, 1'b0, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{1'b1, 2'd0, 32'h1234_5671, 1'b0, 1'b0, 1'b1, 3'd1};
        vecs[7] = '{1'b0, 2'd1, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 3'd0};
        vecs[8] = '{1'b1, 2'd0, 32'h0000_0007, 1'b0, 1'b0, 1'b1, 3'd7};

        // Reset with both requests pending: nothing may leak out.
        irq_notify = 1'b1;
        cfg_valid  = 1'b1;
        cfg_addr   = 2'd2;
        cfg_data   = 32'hFF;
        repeat (2) @(negedge clk);
        check("reset_outputs_zero",
              64'(|{irq_claim_o, irq_complete_o, avm_chipselect_o, avm_read_o, avm_write_o,
                    avm_address_o, avm_writedata_o, cfg_ready_o, core_irq_o, core_irq_id_o,
                    busy_o, spurious_cnt_o}), 64'd0);
        @(posedge clk);
        #1;
        irq_notify = 1'b0;
        cfg_valid  = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 64'(busy_o), 64'd0);
        check("post_reset_spur", 64'(spurious_cnt_o), 64'd0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_irq)
                run_irq(vecs[i].data, vecs[i].exp_irq, vecs[i].exp_id,
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            else
                run_cfg(vecs[i].addr, vecs[i].data, vecs[i].exp_ready, vecs[i].exp_wr);
        end

        // Handshake corners: eoi before ack, ack+eoi together, late eoi held.
        wait_idle(ic);
        rsp_data = 32'h4;
        exp_q.push_back(EXP_RD);
        @(posedge clk);
        #1 irq_notify = 1'b1;
        wait_claim(cc, ok);
        @(posedge clk);
        #1 irq_notify = 1'b0;
        while (cyc < cc + 5) @(negedge clk);
        check("hs_present", 64'(core_irq_o), 64'd1);
        check("hs_id", 64'(core_irq_id_o), 64'd4);
        cb = complete_cnt;
        @(posedge clk);
        #1 core_eoi = 1'b1;
        repeat (2) @(negedge clk);
        check("hs_eoi_before_ack", 64'(core_irq_o), 64'd1);
        @(posedge clk);
        #1 core_ack = 1'b1;
        @(posedge clk);
        #1;
        core_ack = 1'b0;
        core_eoi = 1'b0;
        repeat (3) @(negedge clk);
        check("hs_ack_eoi_irq_off", 64'(core_irq_o), 64'd0);
        check("hs_ack_eoi_in_service", 64'(busy_o), 64'd1);
        check("hs_ack_eoi_no_complete", 64'(complete_cnt - cb), 64'd0);
        @(posedge clk);
        #1 core_eoi = 1'b1;
        repeat (2) @(posedge clk);
        #1 core_eoi = 1'b0;
        wait_idle(ic);
        check("hs_single_complete", 64'(complete_cnt - cb), 64'd1);
        check("hs_guard_len", 64'(ic - complete_c), 64'd3);

        // Notify and config together: claim wins, config waits out GUARD.
        wait_idle(ic);
        rsp_data = 32'h6;
        exp_q.push_back(EXP_RD);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_5A5A});
        @(posedge clk);
        #1;
        irq_notify = 1'b1;
        cfg_valid  = 1'b1;
        cfg_addr   = 2'd1;
        cfg_data   = 32'h0000_5A5A;
        @(negedge clk);
        check("sim_cfg_loses", 64'(cfg_ready_o), 64'd0);
        wait_claim(cc, ok);
        @(posedge clk);
        #1 irq_notify = 1'b0;
        while (cyc < cc + 5) @(negedge clk);
        check("sim_present", 64'(core_irq_o), 64'd1);
        check("sim_id", 64'(core_irq_id_o), 64'd6);
        service(3'd6, 0, 1);
        check("sim_cfg_after_guard", 64'(cfg_ready_o), 64'd1);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("sim_sb_drained", 64'(exp_q.size()), 64'd0);

        // Spurious counter saturation.
        repeat (300) run_irq(32'h0, 1'b0, 3'd0, 0, 0);
        check("spur_saturated", 64'(spurious_cnt_o), 64'd255);

        // Reset in the middle of RD_WAIT.
        wait_idle(ic);
        cb = complete_cnt;
        rsp_data = 32'h3;
        exp_q.push_back(EXP_RD);
        @(posedge clk);
        #1 irq_notify = 1'b1;
        wait_claim(cc, ok);
        @(posedge clk);
        #1 irq_notify = 1'b0;
        while (cyc < cc + 3) @(negedge clk);
        check("mid_reset_read_seen", 64'(avm_read_o), 64'd1);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("mid_reset_outputs_zero",
              64'(|{irq_claim_o, irq_complete_o, avm_chipselect_o, avm_read_o, avm_write_o,
                    avm_address_o, avm_writedata_o, cfg_ready_o, core_irq_o, core_irq_id_o,
                    busy_o, spurious_cnt_o}), 64'd0);
        spur_exp = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_reset_idle", 64'(busy_o), 64'd0);
        check("mid_reset_no_irq", 64'(core_irq_o), 64'd0);
        check("mid_reset_no_complete", 64'(complete_cnt - cb), 64'd0);

        // Controller is fully usable afterwards.
        run_irq(32'h2, 1'b1, 3'd2, 1, 0);
        run_cfg(2'd2, 32'h0000_0249, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check("final_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
